// File: rtl/key_event_spi_tx.sv
`timescale 1ns/1ps
// Keyboard event transmitter: buffers scanner event strobes in a FIFO and
// shifts one {ovf, code} byte per SPI frame (mode 0 slave, MSB first).
// IRQ stays high while events are pending.
module key_event_spi_tx #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              keyEventReady,
  input  logic [6:0]        keyEvent,
  input  logic              SEL,
  input  logic              SCK,
  output logic              SDO,
  output logic              SDO_OE,
  output logic              IRQ,
  output logic [ADDR_W:0]   level
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // [0],[1] synchronise; [2] holds the previous synchronised value for edges
  logic [2:0] sel_sync;
  logic [2:0] sck_sync;
  logic       sel_fall, sel_rise, sck_rise, sck_fall;
  logic       sel_low;

  // FIFO storage and bookkeeping
  logic [6:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count;
  logic              ovf;
  logic              irq_q;
  logic              full, empty;
  logic              push_ok, drop, pop, clr_ovf;
  logic [6:0]        head;

  // Frame FSM state
  state_t      state, state_n;
  logic [3:0]  bit_cnt, bit_cnt_n;
  logic [7:0]  shreg, shreg_n;
  logic        had_evt, had_evt_n;
  logic        had_ovf, had_ovf_n;

  // SPI pins are asynchronous: two-flop synchronise plus one edge-detect stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_sync <= '1;
      sck_sync <= '0;
    end else begin
      sel_sync <= {sel_sync[1:0], SEL};
      sck_sync <= {sck_sync[1:0], SCK};
    end
  end

  assign sel_low  = ~sel_sync[1];
  assign sel_fall =  sel_sync[2] & ~sel_sync[1];
  assign sel_rise = ~sel_sync[2] &  sel_sync[1];
  assign sck_rise = ~sck_sync[2] &  sck_sync[1];
  assign sck_fall =  sck_sync[2] & ~sck_sync[1];

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign head  = empty ? 7'h00 : mem[rd_ptr];

  // A full FIFO still accepts a push when a pop lands in the same cycle
  assign push_ok = keyEventReady & (~full | pop);
  assign drop    = keyEventReady & full & ~pop;

  // Event storage; no reset needed, occupancy is tracked by count
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= keyEvent;
    end
  end

  // Pointers, occupancy, sticky overflow and registered IRQ
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
      // a drop in the same cycle wins over clearing, so no loss goes unreported
      if (drop) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end
      irq_q <= ~empty;
    end
  end

  // Frame FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      had_evt <= 1'b0;
      had_ovf <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      had_evt <= had_evt_n;
      had_ovf <= had_ovf_n;
    end
  end

  // Frame FSM next state: snapshot on select, count rises, shift on falls
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    had_evt_n = had_evt;
    had_ovf_n = had_ovf;
    pop       = 1'b0;
    clr_ovf   = 1'b0;
    case (state)
      IDLE: begin
        if (sel_fall) begin
          shreg_n   = {ovf, head};
          had_evt_n = ~empty;
          had_ovf_n = ovf;
          bit_cnt_n = '0;
          state_n   = SHIFT;
        end
      end
      SHIFT: begin
        if (sel_rise) begin
          state_n = IDLE;
        end else if (sck_rise) begin
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            state_n = DONE;
          end
        end else if (sck_fall && (bit_cnt != 4'd0)) begin
          shreg_n = {shreg[6:0], 1'b0};
        end
      end
      DONE: begin
        if (sel_rise) begin
          pop     = had_evt;
          clr_ovf = had_ovf;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign SDO    = shreg[7] & sel_low;
  assign SDO_OE = sel_low;
  assign IRQ    = irq_q;
  assign level  = count;

endmodule

// File: tb/tb_key_event_spi_tx.sv
`timescale 1ns/1ps
module tb_key_event_spi_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       keyEventReady;
  logic [6:0] keyEvent;
  logic       SEL;
  logic       SCK;
  logic       SDO;
  logic       SDO_OE;
  logic       IRQ;
  logic [4:0] level;

  int total = 0;
  int bad   = 0;

  typedef enum {OP_PUSH, OP_FRAME, OP_ABORT} op_t;
  typedef struct {
    op_t        op;
    logic [6:0] code;
    logic [7:0] exp_byte;
    int         exp_level;
  } vec_t;

  vec_t       vt[$];
  logic [6:0] mq[$];
  logic       m_ovf;

  key_event_spi_tx #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .keyEventReady(keyEventReady), .keyEvent(keyEvent),
    .SEL(SEL), .SCK(SCK), .SDO(SDO), .SDO_OE(SDO_OE), .IRQ(IRQ), .level(level)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_burst(input int n, input logic use_model);
    for (int i = 0; i < n; i++) begin
      logic [6:0] c;
      c = 7'($urandom_range(0, 127));
      keyEventReady = 1'b1;
      keyEvent      = c;
      if (use_model) begin
        if (mq.size() < 16) mq.push_back(c);
        else m_ovf = 1'b1;
      end
      tick(1);
    end
    keyEventReady = 1'b0;
    tick(2);
  endtask

  task automatic push_code(input logic [6:0] c);
    keyEventReady = 1'b1;
    keyEvent      = c;
    tick(1);
    keyEventReady = 1'b0;
    tick(2);
  endtask

  // Host side of one frame; optionally strobes an event so it lands in the pop cycle
  task automatic spi_frame(input int nbits, input logic coincide, input logic [6:0] ccode,
                           output logic [7:0] rx);
    rx  = '0;
    SEL = 1'b0;
    tick(6);
    check("sdo_oe_in_frame", 32'(SDO_OE), 32'd1);
    for (int i = 0; i < nbits; i++) begin
      rx  = {rx[6:0], SDO};
      SCK = 1'b1;
      tick(6);
      SCK = 1'b0;
      tick(6);
    end
    SEL = 1'b1;
    if (coincide) begin
      tick(2);
      keyEventReady = 1'b1;
      keyEvent      = ccode;
      tick(1);
      keyEventReady = 1'b0;
      tick(6);
    end else begin
      tick(9);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(2);
    mq.delete();
    m_ovf = 1'b0;
  endtask

  initial begin
    logic [7:0] rx;
    rst = 1'b0; keyEventReady = 1'b0; keyEvent = '0; SEL = 1'b1; SCK = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    tick(3);
    check("reset_sdo", 32'(SDO), 32'd0);
    check("reset_sdo_oe", 32'(SDO_OE), 32'd0);
    check("reset_irq", 32'(IRQ), 32'd0);
    check("reset_level", 32'(level), 32'd0);
    rst = 1'b1;
    tick(2);

    // push-to-IRQ latency: level one cycle after the strobe, IRQ one cycle later
    keyEventReady = 1'b1;
    keyEvent      = 7'h2A;
    tick(1);
    keyEventReady = 1'b0;
    check("push_level_n1", 32'(level), 32'd1);
    check("push_irq_n1", 32'(IRQ), 32'd0);
    tick(1);
    check("push_irq_n2", 32'(IRQ), 32'd1);

    // directed vector table
    vt.push_back('{OP_FRAME, 7'h00, 8'h2A, 0});
    vt.push_back('{OP_FRAME, 7'h00, 8'h00, 0});
    vt.push_back('{OP_PUSH,  7'h05, 8'h00, 1});
    vt.push_back('{OP_ABORT, 7'h00, 8'h00, 1});
    vt.push_back('{OP_FRAME, 7'h00, 8'h05, 0});
    for (int i = 1; i <= 17; i++)
      vt.push_back('{OP_PUSH, 7'(i), 8'h00, (i > 16) ? 16 : i});
    vt.push_back('{OP_FRAME, 7'h00, 8'h81, 15});
    for (int i = 2; i <= 16; i++)
      vt.push_back('{OP_FRAME, 7'h00, 8'(i), 16 - i});
    vt.push_back('{OP_FRAME, 7'h00, 8'h00, 0});

    for (int i = 0; i < vt.size(); i++) begin
      case (vt[i].op)
        OP_PUSH: push_code(vt[i].code);
        OP_ABORT: spi_frame(4, 1'b0, 7'h00, rx);
        default: begin
          spi_frame(8, 1'b0, 7'h00, rx);
          check($sformatf("vec%0d_byte", i), 32'(rx), 32'(vt[i].exp_byte));
        end
      endcase
      check($sformatf("vec%0d_level", i), 32'(level), 32'(vt[i].exp_level));
      check($sformatf("vec%0d_irq", i), 32'(IRQ), (vt[i].exp_level != 0) ? 32'd1 : 32'd0);
    end

    // full FIFO: push coinciding with the pop is accepted without overflow
    for (int i = 0; i < 16; i++) push_code(7'(8'h40 + i));
    check("simul_fill_level", 32'(level), 32'd16);
    spi_frame(8, 1'b1, 7'h7F, rx);
    check("simul_first_byte", 32'(rx), 32'h40);
    check("simul_level", 32'(level), 32'd16);
    for (int i = 1; i < 16; i++) begin
      spi_frame(8, 1'b0, 7'h00, rx);
      check($sformatf("simul_byte%0d", i), 32'(rx), 32'(8'h40 + i));
    end
    spi_frame(8, 1'b0, 7'h00, rx);
    check("simul_last_7f", 32'(rx), 32'h7F);
    check("simul_empty_level", 32'(level), 32'd0);

    // reset in the middle of a frame
    push_code(7'h11);
    push_code(7'h22);
    SEL = 1'b0;
    tick(6);
    for (int i = 0; i < 3; i++) begin
      SCK = 1'b1; tick(6); SCK = 1'b0; tick(6);
    end
    rst = 1'b0;
    tick(2);
    check("midrst_sdo", 32'(SDO), 32'd0);
    check("midrst_sdo_oe", 32'(SDO_OE), 32'd0);
    check("midrst_irq", 32'(IRQ), 32'd0);
    check("midrst_level", 32'(level), 32'd0);
    rst = 1'b1;
    tick(1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("midrst_tail_sdo%0d", i), 32'(SDO), 32'd0);
      SCK = 1'b1; tick(6); SCK = 1'b0; tick(6);
    end
    SEL = 1'b1;
    tick(9);
    spi_frame(8, 1'b0, 7'h00, rx);
    check("midrst_next_byte", 32'(rx), 32'h00);
    check("midrst_next_level", 32'(level), 32'd0);

    // randomized traffic against a queue model
    do_reset();
    for (int it = 0; it < 70; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 3) begin
        push_burst(1, 1'b1);
      end else if (r == 4) begin
        push_burst($urandom_range(2, 20), 1'b1);
      end else if (r <= 7) begin
        logic [7:0] exp;
        exp = {m_ovf, (mq.size() != 0) ? mq[0] : 7'h00};
        spi_frame(8, 1'b0, 7'h00, rx);
        if (mq.size() != 0) void'(mq.pop_front());
        m_ovf = 1'b0;
        check($sformatf("rnd%0d_byte", it), 32'(rx), 32'(exp));
      end else begin
        spi_frame($urandom_range(1, 7), 1'b0, 7'h00, rx);
      end
      check($sformatf("rnd%0d_level", it), 32'(level), 32'(mq.size()));
      check($sformatf("rnd%0d_irq", it), 32'(IRQ), (mq.size() != 0) ? 32'd1 : 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
